// File: rtl/instr_fetch_ctrl.sv
// rtl/instr_fetch_ctrl.sv - instruction fetch sequencer: PC, imem read port, prefetch FIFO, redirect/halt
// Optional out-of-range fetch check enabled by `IFETCH_BOUNDS_CHECK_EN.
module instr_fetch_ctrl #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [15:0] HALT_WORD  = 16'hFFFF,
  parameter int          MEM_WORDS  = 32768
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic [15:0] imemAdr,
  input  logic [15:0] imemData,
  output logic [15:0] instr,
  output logic [15:0] instrPc,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [15:0] redirectPc,
  output logic        halted,
  output logic        fault
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_HALTED
  } state_t;

  state_t        state, state_nxt;
  logic [15:0]   pc, pc_nxt;
  logic [15:0]   fifo_data [FIFO_DEPTH];
  logic [15:0]   fifo_pc   [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          full, empty;
  logic          push, pop, flush;
  logic          oob, fault_set;

  assign empty = (count == '0);
  assign full  = (count == CW'(FIFO_DEPTH));

`ifdef IFETCH_BOUNDS_CHECK_EN
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_WORDS);
  logic fault_q;

  assign oob   = ({16'h0000, pc} >= MEM_LIMIT);
  assign fault = fault_q;

  // Sticky until reset; a redirect out of HALTED deliberately leaves it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end
  end
`else
  logic unused_cfg;

  assign oob        = 1'b0;
  assign fault      = 1'b0;
  assign unused_cfg = fault_set ^ (MEM_WORDS != 0);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      pc    <= RESET_PC;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
    end
  end

  // Redirect wins over everything: it flushes, blocks push and pop, and reloads PC.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    push      = 1'b0;
    pop       = 1'b0;
    flush     = 1'b0;
    fault_set = 1'b0;
    if (redirect) begin
      flush  = 1'b1;
      pc_nxt = redirectPc;
      if (state != S_IDLE) begin
        state_nxt = S_FETCH;
      end
    end else begin
      pop = !empty && instrReady;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state_nxt = S_FETCH;
            pc_nxt    = RESET_PC;
            flush     = 1'b1;
          end
        end
        S_FETCH: begin
          if (!full || pop) begin
            if (oob) begin
              fault_set = 1'b1;
              state_nxt = S_HALTED;
            end else begin
              push   = 1'b1;
              pc_nxt = pc + 16'd1;
              if (imemData == HALT_WORD) begin
                state_nxt = S_HALTED;
              end
            end
          end
        end
        S_HALTED: begin
          state_nxt = S_HALTED;
        end
        default: begin
          state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imemData;
      fifo_pc[wr_ptr]   <= pc;
    end
  end

  assign imemAdr    = pc;
  assign instrValid = !empty;
  assign instr      = empty ? 16'h0000 : fifo_data[rd_ptr];
  assign instrPc    = empty ? 16'h0000 : fifo_pc[rd_ptr];
  assign halted     = (state == S_HALTED);

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb/tb_instr_fetch_ctrl.sv - scoreboard bench for instr_fetch_ctrl
module tb_instr_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        instrReady = 1'b0;
  logic        redirect = 1'b0;
  logic [15:0] redirectPc = 16'h0000;
  logic [15:0] imemAdr, imemData, instr, instrPc;
  logic        instrValid, halted, fault;

  logic [15:0] mem [0:65535];
  logic [31:0] expq [$];
  int          checks = 0;
  int          errors = 0;

  assign imemData = mem[imemAdr];

  always #5 clk = ~clk;

  instr_fetch_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .imemAdr    (imemAdr),
    .imemData   (imemData),
    .instr      (instr),
    .instrPc    (instrPc),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .redirect   (redirect),
    .redirectPc (redirectPc),
    .halted     (halted),
    .fault      (fault)
  );

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return a + 16'h1001;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_run(input logic [15:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] a;
      a = first + 16'(i);
      expq.push_back({a, word_at(a)});
    end
  endtask

  task automatic wait_drain(input string name, input int limit);
    int n;
    n = 0;
    while (expq.size() != 0 && n < limit) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, expq.size(), 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && instrValid && instrReady && !redirect) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_delivery actual=%h/%h expected=none", instrPc, instr);
        end else begin
          e = expq.pop_front();
          if ({instrPc, instr} !== e) begin
            errors++;
            $display("FAIL delivery actual=%h/%h expected=%h/%h", instrPc, instr, e[31:16], e[15:0]);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stim
    for (int i = 0; i < 65536; i++) mem[i] = word_at(16'(i));
    #2;

    // reset state
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_valid", instrValid, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instrPc, 0);
    chk("rst_halted", halted, 0);
    chk("rst_fault", fault, 0);
    chk("rst_adr", imemAdr, 0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_fetch", instrValid, 0);

    // start with decode always ready
    instrReady = 1'b1;
    expect_run(16'h0000, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    chk("start_n1_valid", instrValid, 0);
    tick();
    @(negedge clk);
    chk("start_n2_valid", instrValid, 1);
    wait_drain("start_stream", 4);
    instrReady = 1'b0;

    // backpressure
    do_reset();
    expect_run(16'h0000, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    @(negedge clk);
    chk("bp_pc_stall", imemAdr, 16'h0002);
    chk("bp_valid", instrValid, 1);
    tick();
    instrReady = 1'b1;
    wait_drain("bp_release", 3);
    instrReady = 1'b0;

    // redirect while full
    tick();
    @(negedge clk);
    chk("rd_full_pc", imemAdr, 16'h0005);
    tick();
    redirect = 1'b1;
    redirectPc = 16'h0040;
    instrReady = 1'b1;
    expq.delete();
    expect_run(16'h0040, 4);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("rd_n1_valid", instrValid, 0);
    tick();
    @(negedge clk);
    chk("rd_n2_valid", instrValid, 1);
    chk("rd_n2_pc", instrPc, 16'h0040);
    wait_drain("rd_stream", 4);
    instrReady = 1'b0;

    // halt word at address 2
    mem[2] = 16'hFFFF;
    do_reset();
    instrReady = 1'b1;
    expq.push_back({16'h0000, 16'h1001});
    expq.push_back({16'h0001, 16'h1002});
    expq.push_back({16'h0002, 16'hFFFF});
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("halt_n3", halted, 0);
    tick();
    @(negedge clk);
    chk("halt_n4", halted, 1);
    repeat (3) tick();
    @(negedge clk);
    chk("halt_adr", imemAdr, 16'h0003);
    chk("halt_empty", instrValid, 0);
    chk("halt_drained", expq.size(), 0);
    tick();
    redirect = 1'b1;
    redirectPc = 16'h0000;
    expect_run(16'h0000, 2);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("halt_resume", halted, 0);
    wait_drain("halt_resume_stream", 4);
    instrReady = 1'b0;
    mem[2] = word_at(16'h0002);

    // end of memory
    tick();
    redirect = 1'b1;
    redirectPc = 16'h7FFF;
    instrReady = 1'b1;
    expq.delete();
`ifdef IFETCH_BOUNDS_CHECK_EN
    expq.push_back({16'h7FFF, 16'h9000});
`else
    expect_run(16'h7FFF, 3);
`endif
    tick();
    redirect = 1'b0;
    tick();
    tick();
    @(negedge clk);
`ifdef IFETCH_BOUNDS_CHECK_EN
    chk("oob_fault", fault, 1);
    chk("oob_halted", halted, 1);
    chk("oob_adr", imemAdr, 16'h8000);
`else
    chk("nochk_fault", fault, 0);
    chk("nochk_halted", halted, 0);
`endif
    wait_drain("edge_stream", 3);
    instrReady = 1'b0;
`ifdef IFETCH_BOUNDS_CHECK_EN
    tick();
    redirect = 1'b1;
    redirectPc = 16'h0010;
    tick();
    redirect = 1'b0;
    @(negedge clk);
    chk("oob_sticky", fault, 1);
`else
    tick();
    redirect = 1'b1;
    redirectPc = 16'hFFFF;
    instrReady = 1'b1;
    expq.delete();
    expq.push_back({16'hFFFF, 16'h1000});
    expq.push_back({16'h0000, 16'h1001});
    tick();
    redirect = 1'b0;
    wait_drain("pc_wrap", 4);
    instrReady = 1'b0;
`endif

    // asynchronous reset mid-stream
    do_reset();
    instrReady = 1'b1;
    expect_run(16'h0000, 10);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", instrValid, 0);
    chk("arst_instr", instr, 0);
    chk("arst_pc", instrPc, 0);
    chk("arst_adr", imemAdr, 0);
    chk("arst_halted", halted, 0);
    chk("arst_fault", fault, 0);
    expq.delete();
    tick();
    rst_n = 1'b1;
    expect_run(16'h0000, 4);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain("arst_restart", 5);
    instrReady = 1'b0;

    tick();
    chk("final_queue", expq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
